// File: rtl/invsqrt_lut_arbiter.sv
// invsqrt_lut_arbiter
//   Shares one single-port inverse-square-root LUT BRAM (1-cycle registered read)
//   between N_REQ lanes. The arbiter is round-robin, and each lane can have at most
//   one lookup outstanding. A result is held in a per-lane register until the lane
//   accepts it.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-lane lookup request
//   req_addr   per-lane LUT address, lane i at [i*ADDR_LENGTH +: ADDR_LENGTH]
//   req_ready  one-hot grant (handshake = req_valid & req_ready)
//   rsp_valid  per-lane result available
//   rsp_data   per-lane held result, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_ready  per-lane result accept
//   bram_en    BRAM read enable
//   bram_addr  BRAM read address
//   bram_data  BRAM registered read data, valid the cycle after bram_en

module invsqrt_lut_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ADDR_LENGTH = 12,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ*ADDR_LENGTH-1:0]    req_addr,
  output logic [N_REQ-1:0]                req_ready,
  output logic [N_REQ-1:0]                rsp_valid,
  output logic [N_REQ*DATA_WIDTH-1:0]     rsp_data,
  input  logic [N_REQ-1:0]                rsp_ready,
  output logic                            bram_en,
  output logic [ADDR_LENGTH-1:0]          bram_addr,
  input  logic [DATA_WIDTH-1:0]           bram_data
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PtrW-1:0]             rr_ptr_q, rr_ptr_d;
  logic                        pend_valid_q;
  logic [PtrW-1:0]             pend_id_q;
  logic [N_REQ-1:0]            rsp_valid_q, rsp_valid_d;
  logic [N_REQ*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [N_REQ-1:0]            eligible;
  logic                        grant_found;
  logic [PtrW-1:0]             grant_id;
  logic                        grant;

  // A lane may not be granted while its previous lookup is in flight or its
  // result is still unaccepted. Only registered state is used here.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && !rsp_valid_q[i] &&
                    !(pend_valid_q && (pend_id_q == PtrW'(i)));
    end
  end

  // Priority search starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_id    = PtrW'(idx);
      end
    end
  end

  // Outputs are forced quiet while reset is asserted, even though the
  // registered state would otherwise select lane 0.
  assign grant = grant_found && rst_n;

  always_comb begin
    req_ready = '0;
    bram_addr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant && (grant_id == PtrW'(i))) begin
        req_ready[i] = 1'b1;
        bram_addr    = req_addr[i*ADDR_LENGTH +: ADDR_LENGTH];
      end
    end
  end

  assign bram_en = grant;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (grant_id == PtrW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Accept clears the valid bit; capture of the in-flight lookup sets it.
  // Both cannot target the same lane in one cycle, since eligibility blocks it.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rsp_valid_q[i] && rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
      if (pend_valid_q && (pend_id_q == PtrW'(i))) begin
        rsp_valid_d[i]                         = 1'b1;
        rsp_data_d[i*DATA_WIDTH +: DATA_WIDTH] = bram_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_id_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      pend_valid_q <= grant;
      if (grant) begin
        pend_id_q <= grant_id;
      end
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: doc/invsqrt_lut_arbiter.md
Name: invsqrt_lut_arbiter

Overview:
Shares one single-port inverse-square-root LUT BRAM (1-cycle registered read, S -> 1/sqrt(S)) between N_REQ ray-marcher lanes. Each lane has its own valid/ready request channel and a held response channel. The block does round-robin arbitration and drives the BRAM enable and address. It tracks the in-flight read and returns the data to the owning lane, with at most one outstanding lookup per lane.

Parameters:
N_REQ, 4, number of requesting lanes (2..8)
ADDR_LENGTH, 12, LUT address width
DATA_WIDTH, 32, LUT data width

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-lane lookup request
req_addr  in  N_REQ*ADDR_LENGTH  per-lane LUT address; lane i occupies bits [i*ADDR_LENGTH +: ADDR_LENGTH]
req_ready  out  N_REQ  one-hot grant; a handshake occurs when req_valid[i] and req_ready[i] are both high
rsp_valid  out  N_REQ  per-lane result available
rsp_data  out  N_REQ*DATA_WIDTH  per-lane result register; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
rsp_ready  in  N_REQ  per-lane result accept
bram_en  out  1  BRAM read enable
bram_addr  out  ADDR_LENGTH  BRAM read address
bram_data  in  DATA_WIDTH  BRAM registered read data, valid in the cycle after bram_en

Behaviour:
- Reset (async assert, sync release): rr_ptr=0, pend_valid=0, pend_id=0, rsp_valid=0, rsp_data=0. req_ready, bram_en and bram_addr evaluate to 0.
- Eligibility, lane i: req_valid[i] && !rsp_valid[i] && !(pend_valid && pend_id==i). Uses registered state only, so a lane whose response is accepted in cycle C becomes eligible in C+1.
- Grant: combinational priority search over eligible lanes, starting at rr_ptr and wrapping modulo N_REQ. Result g is at most one lane.
  - If a lane is granted: req_ready = one-hot(g), bram_en=1, bram_addr=req_addr[g].
  - If no lane is granted: req_ready=0, bram_en=0, bram_addr=0.
- On a grant at the clock edge: rr_ptr <= (g+1) mod N_REQ; pend_valid <= 1; pend_id <= g.
  - With no grant, rr_ptr holds and pend_valid <= 0.
- Pipeline: handshake in cycle T; BRAM output is valid in T+1. At the end of T+1, rsp_data[pend_id] <= bram_data and rsp_valid[pend_id] <= 1. rsp_valid is therefore visible from T+2.
  - Fixed latency: handshake to rsp_valid = 2 cycles.
- Response hold: rsp_valid[i] and rsp_data[i] stay stable until a cycle with rsp_valid[i] && rsp_ready[i]. At the end of that cycle rsp_valid[i] <= 0; rsp_data[i] keeps its value.
- Simultaneous events:
  - A capture for lane i and an accept for lane i cannot coincide, because eligibility blocks it.
  - Captures for one lane and accepts for other lanes in the same cycle are independent.
  - A new grant and a capture in the same cycle are allowed: back-to-back grants give one lookup per clock.
- Throughput:
  - With N_REQ>=3 lanes all requesting and rsp_ready tied high, a grant issues every cycle.
  - A single lane alone gets one grant per 3 cycles.
- req_addr of a lane is sampled only in its grant cycle. Changing it at any other time has no effect.
- Reset mid-operation: the in-flight lookup and all held responses are discarded. After release there is no spurious rsp_valid, and arbitration restarts at lane 0.
- The BRAM output register is not reset. bram_data is consumed only when pend_valid=1.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> req_ready=0, bram_en=0, bram_addr=0, rsp_valid=0. Release with only lane 0 valid -> lane 0 granted first.
- Single lookup: lane 2 requests addr 0x123 at cycle T, LUT[0x123]=0x3F000000 -> at T: req_ready=4'b0100, bram_en=1, bram_addr=0x123. At T+2: rsp_valid[2]=1, rsp_data[2]=0x3F000000. rsp_ready[2]=0 for 5 cycles -> data held, no regrant. Then rsp_ready[2]=1 -> rsp_valid[2] clears next cycle.
- Round-robin: all 4 lanes request continuously, rsp_ready=4'b1111 -> grants 0,1,2,3,0,1,... on consecutive cycles. bram_en stays high every cycle and each lane sees rsp_valid 2 cycles after its grant.
- Backpressure isolation: as above but rsp_ready[1]=0 -> after its first response, lane 1 is skipped and the order becomes 0,2,3,0,2,3. Raise rsp_ready[1] -> lane 1 rejoins the rotation from the cycle after it accepts.
- Accept/request same cycle: lane 0 alone, rsp_valid[0]=1, rsp_ready[0]=1, req_valid[0]=1 -> no grant that cycle; grant in the next cycle.
- Reset mid-flight: lane 3 granted at T, rst_n low during T+1, released at T+3 -> no rsp_valid[3] ever appears and rr_ptr=0. All lanes then requesting -> lane 0 granted first.
